multdiv: RTL and testbench

Iterative signed 32-bit multiply/divide unit that sits beside the ALU in the execute stage of the skeleton processor. The processor pulses a start control with two operands, the unit computes over WIDTH cycles, and then returns a result, an exception flag and a one-cycle ready strobe. The processor's stall logic and register writeback consume these outputs (writeback to the destination register, or to rstatus on exception).

---
 rtl/multdiv_if.sv | 20 ++
 rtl/multdiv.sv | 124 ++++++++++++
 tb/tb_multdiv.sv | 108 ++++++++++
 3 files changed

// File: rtl/multdiv_if.sv
// Start/operand/result bundle between the execute stage and the multiply/divide unit.
interface multdiv_if #(parameter int WIDTH = 32);
    logic             ctrl_MULT;
    logic             ctrl_DIV;
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;
    logic             busy;

    modport master (
        output ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
        input  data_result, data_exception, data_resultRDY, busy
    );
    modport slave (
        input  ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
        output data_result, data_exception, data_resultRDY, busy
    );
endinterface

// File: rtl/multdiv.sv
// Iterative signed multiply (shift-add) / divide (restoring) unit, WIDTH cycles per operation.
// Both operate on magnitudes; the sign and overflow fix-up is folded into the final iteration.
module multdiv #(
    parameter int WIDTH = 32
) (
    input  logic     clock,
    input  logic     reset,
    multdiv_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t             state, state_nxt;
    logic [CW-1:0]      cnt;
    logic               start_mul, start_div, last;
    logic [WIDTH-1:0]   abs_a, abs_b;

    logic               neg;
    logic [2*WIDTH-1:0] mcand, acc;
    logic [WIDTH-1:0]   opb, rem, quo;
    logic [WIDTH-1:0]   result_q;
    logic               exc_q;
    logic               busy_c, rdy_c;

    assign start_mul = bus.ctrl_MULT & ~bus.ctrl_DIV;
    assign start_div = bus.ctrl_DIV & ~bus.ctrl_MULT;
    assign last      = (cnt == CW'(WIDTH - 1));
    assign abs_a     = bus.data_operandA[WIDTH-1] ? -bus.data_operandA : bus.data_operandA;
    assign abs_b     = bus.data_operandB[WIDTH-1] ? -bus.data_operandB : bus.data_operandB;

    // Multiply step: opb is the multiplier, shifted right while mcand shifts left.
    logic [2*WIDTH-1:0] acc_nxt, prod;
    logic               mul_exc;
    assign acc_nxt = acc + (opb[0] ? mcand : '0);
    assign prod    = neg ? -acc_nxt : acc_nxt;
    assign mul_exc = (prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}});

    // Divide step: opb is the divisor, quo starts as the dividend and fills with quotient bits.
    logic [WIDTH:0]   sh;
    logic [WIDTH-1:0] diff, rem_nxt, quo_nxt, quo_sgn;
    logic             fits, div_zero, div_exc;
    assign sh       = {rem, quo[WIDTH-1]};
    assign fits     = (sh >= {1'b0, opb});
    assign diff     = sh[WIDTH-1:0] - opb;
    assign rem_nxt  = fits ? diff : sh[WIDTH-1:0];
    assign quo_nxt  = {quo[WIDTH-2:0], fits};
    assign quo_sgn  = neg ? -quo_nxt : quo_nxt;
    assign div_zero = (opb == '0);
    // Only most-negative / -1 yields a positive magnitude with the top bit set.
    assign div_exc  = div_zero | (quo_nxt[WIDTH-1] & ~neg);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (start_mul)      state_nxt = MUL;
        else if (start_div) state_nxt = DIV;
        else begin
            case (state)
                MUL, DIV: if (last) state_nxt = DONE;
                DONE:     state_nxt = IDLE;
                default:  state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        busy_c = 1'b0;
        rdy_c  = 1'b0;
        case (state)
            MUL, DIV: busy_c = 1'b1;
            DONE:     rdy_c  = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt      <= '0;
            neg      <= 1'b0;
            mcand    <= '0;
            acc      <= '0;
            opb      <= '0;
            rem      <= '0;
            quo      <= '0;
            result_q <= '0;
            exc_q    <= 1'b0;
        end else if (start_mul || start_div) begin
            cnt   <= '0;
            neg   <= bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
            mcand <= {{WIDTH{1'b0}}, abs_a};
            acc   <= '0;
            opb   <= abs_b;
            rem   <= '0;
            quo   <= abs_a;
        end else if (state == MUL) begin
            cnt   <= cnt + 1'b1;
            acc   <= acc_nxt;
            mcand <= mcand << 1;
            opb   <= opb >> 1;
            if (last) begin
                result_q <= prod[WIDTH-1:0];
                exc_q    <= mul_exc;
            end
        end else if (state == DIV) begin
            cnt <= cnt + 1'b1;
            rem <= rem_nxt;
            quo <= quo_nxt;
            if (last) begin
                result_q <= div_zero ? '0 : quo_sgn;
                exc_q    <= div_exc;
            end
        end
    end

    assign bus.data_result    = result_q;
    assign bus.data_exception = exc_q;
    assign bus.data_resultRDY = rdy_c;
    assign bus.busy           = busy_c;
endmodule

// File: tb/tb_multdiv.sv
// Directed bench for multdiv: latency, signed results, exceptions, restart, conflict and reset.
module tb_multdiv;
    logic clock = 1'b0;
    logic reset = 1'b0;
    int   passed = 0;
    int   total  = 0;

    multdiv_if #(.WIDTH(32)) bus ();
    multdiv #(.WIDTH(32)) dut (.clock(clock), .reset(reset), .bus(bus));

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Pulse a start across one posedge; returns at the negedge after the start edge.
    task automatic start(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        bus.ctrl_MULT = m;  bus.ctrl_DIV = d;
        bus.data_operandA = a;  bus.data_operandB = b;
        @(negedge clock);
        bus.ctrl_MULT = 1'b0;  bus.ctrl_DIV = 1'b0;
        bus.data_operandA = 32'hDEADBEEF;  bus.data_operandB = 32'h0BADF00D;
    endtask

    task automatic wait_rdy(output int n);
        n = 0;
        while (n < 100) begin
            @(posedge clock); #1;
            n++;
            if (bus.data_resultRDY) break;
        end
    endtask

    task automatic no_rdy(input string tag, input int cycles);
        logic seen = 1'b0;
        repeat (cycles) begin
            @(posedge clock); #1;
            if (bus.data_resultRDY) seen = 1'b1;
        end
        chk(tag, {31'b0, seen}, 32'd0);
    endtask

    task automatic op(input string tag, input logic m, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] exp_res, input logic exp_exc);
        int n;
        start(m, ~m, a, b);
        chk({tag, " busy"}, {31'b0, bus.busy}, 32'd1);
        wait_rdy(n);
        chk({tag, " latency"}, n, 32'd32);
        chk({tag, " result"}, bus.data_result, exp_res);
        chk({tag, " exception"}, {31'b0, bus.data_exception}, {31'b0, exp_exc});
        chk({tag, " busy_done"}, {31'b0, bus.busy}, 32'd0);
        @(posedge clock); #1;
        chk({tag, " rdy_one_cycle"}, {31'b0, bus.data_resultRDY}, 32'd0);
    endtask

    initial begin
        int n;
        bus.ctrl_MULT = 1'b0;  bus.ctrl_DIV = 1'b0;
        bus.data_operandA = '0;  bus.data_operandB = '0;
        #23;
        chk("reset result", bus.data_result, 32'd0);
        chk("reset exc", {31'b0, bus.data_exception}, 32'd0);
        chk("reset rdy", {31'b0, bus.data_resultRDY}, 32'd0);
        chk("reset busy", {31'b0, bus.busy}, 32'd0);
        @(negedge clock);
        reset = 1'b1;

        op("mul 6*7",       1'b1, 32'd6,        32'd7,        32'd42,        1'b0);
        op("mul -5*3",      1'b1, -32'sd5,      32'd3,        32'hFFFFFFF1,  1'b0);
        op("mul 2^16*2^16", 1'b1, 32'h00010000, 32'h00010000, 32'd0,         1'b1);
        op("mul min*-1",    1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000,  1'b1);
        op("div 100/7",     1'b0, 32'd100,      32'd7,        32'd14,        1'b0);
        op("div -100/7",    1'b0, -32'sd100,    32'd7,        32'hFFFFFFF2,  1'b0);
        op("div 7/-100",    1'b0, 32'd7,        -32'sd100,    32'd0,         1'b0);
        op("div 5/0",       1'b0, 32'd5,        32'd0,        32'd0,         1'b1);
        op("div min/-1",    1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000,  1'b1);

        // Restart: the aborted multiply must never raise RDY.
        start(1'b1, 1'b0, 32'd3, 32'd3);
        no_rdy("restart pre", 9);
        op("restart div 50/5", 1'b0, 32'd50, 32'd5, 32'd10, 1'b0);

        start(1'b1, 1'b1, 32'd4, 32'd2);
        chk("conflict busy", {31'b0, bus.busy}, 32'd0);
        no_rdy("conflict no rdy", 40);

        // Asynchronous reset mid-multiply, away from any clock edge.
        start(1'b1, 1'b0, 32'd6, 32'd7);
        repeat (14) @(posedge clock);
        #3 reset = 1'b0;
        #1;
        chk("midreset result", bus.data_result, 32'd0);
        chk("midreset busy", {31'b0, bus.busy}, 32'd0);
        chk("midreset rdy", {31'b0, bus.data_resultRDY}, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        no_rdy("midreset no rdy", 40);
        op("post-reset div 9/3", 1'b0, 32'd9, 32'd3, 32'd3, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
